// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus for the RAM port arbiter: one request/response channel.
// The requester drives the command fields; the arbiter returns ack/nack/rdata.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req;
  logic              wren;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              nack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, wren, addr, wdata, input ack, nack, rdata);
  modport slave  (input req, wren, addr, wdata, output ack, nack, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous single-port RAM between the I2C memory path (priority)
// and a local host bus. Each access runs IDLE -> ACCESS -> CAPTURE -> RESP;
// out-of-range addresses skip the RAM and answer with a nack straight from IDLE.
// A saturating wait counter forces the host in after MAX_WAIT back-to-back
// I2C grants so the host cannot be starved.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_port_arbiter_if.slave i2c_bus,
  ram_port_arbiter_if.slave host_bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int unsigned       WCNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_ACCESS  = 4'b0010,
    ST_CAPTURE = 4'b0100,
    ST_RESP    = 4'b1000
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;        // 0 = I2C, 1 = host
  logic              wren_q, wren_d;          // latched operation of the owner
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;  // doubles as the latched address
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              ram_wren_q, ram_wren_d;
  logic              ram_rden_q, ram_rden_d;
  logic              i2c_ack_q, i2c_ack_d;
  logic              i2c_nack_q, i2c_nack_d;
  logic              host_ack_q, host_ack_d;
  logic              host_nack_q, host_nack_d;
  logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic              host_win;
  logic              sel_wren;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oor;

  // State and output registers; reset abandons any access without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      wren_q       <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_wren_q   <= 1'b0;
      ram_rden_q   <= 1'b0;
      i2c_ack_q    <= 1'b0;
      i2c_nack_q   <= 1'b0;
      host_ack_q   <= 1'b0;
      host_nack_q  <= 1'b0;
      i2c_rdata_q  <= '0;
      host_rdata_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wren_q       <= wren_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_wren_q   <= ram_wren_d;
      ram_rden_q   <= ram_rden_d;
      i2c_ack_q    <= i2c_ack_d;
      i2c_nack_q   <= i2c_nack_d;
      host_ack_q   <= host_ack_d;
      host_nack_q  <= host_nack_d;
      i2c_rdata_q  <= i2c_rdata_d;
      host_rdata_q <= host_rdata_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Arbitration, sequencing and response generation; pulses default low.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wren_d       = wren_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_wren_d   = 1'b0;
    ram_rden_d   = 1'b0;
    i2c_ack_d    = 1'b0;
    i2c_nack_d   = 1'b0;
    host_ack_d   = 1'b0;
    host_nack_d  = 1'b0;
    i2c_rdata_d  = i2c_rdata_q;
    host_rdata_d = host_rdata_q;
    wait_cnt_d   = wait_cnt_q;

    host_win  = host_bus.req && (!i2c_bus.req || (wait_cnt_q == WAIT_MAX));
    sel_wren  = host_win ? host_bus.wren  : i2c_bus.wren;
    sel_addr  = host_win ? host_bus.addr  : i2c_bus.addr;
    sel_wdata = host_win ? host_bus.wdata : i2c_bus.wdata;
    sel_oor   = (32'(sel_addr) >= DEPTH);

    case (state_q)
      ST_IDLE: begin
        if (!host_bus.req) begin
          wait_cnt_d = '0;
        end
        if (i2c_bus.req || host_bus.req) begin
          owner_d = host_win;
          wren_d  = sel_wren;
          if (host_win) begin
            wait_cnt_d = '0;
          end else if (host_bus.req && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
          if (sel_oor) begin
            // Out of range: no RAM cycle, answer on the next cycle.
            state_d     = ST_RESP;
            host_nack_d = host_win;
            i2c_nack_d  = !host_win;
          end else begin
            state_d     = ST_ACCESS;
            ram_addr_d  = sel_addr;
            ram_wdata_d = sel_wdata;
            ram_wren_d  = sel_wren;
            ram_rden_d  = !sel_wren;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // ram_q is valid here, one cycle after the read enable.
        if (!wren_q) begin
          if (owner_q) host_rdata_d = ram_q;
          else         i2c_rdata_d  = ram_q;
        end
        host_ack_d = owner_q;
        i2c_ack_d  = !owner_q;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ram_addr       = ram_addr_q;
  assign ram_wdata      = ram_wdata_q;
  assign ram_wren       = ram_wren_q;
  assign ram_rden       = ram_rden_q;
  assign i2c_bus.ack    = i2c_ack_q;
  assign i2c_bus.nack   = i2c_nack_q;
  assign i2c_bus.rdata  = i2c_rdata_q;
  assign host_bus.ack   = host_ack_q;
  assign host_bus.nack  = host_nack_q;
  assign host_bus.rdata = host_rdata_q;

endmodule
